// File: rtl/video_timing_pkg.sv
// Shared constants and types for the video timing generator: default
// 640x480 timing, pattern-select encodings and the fixed colours.
package video_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic [1:0] {
        PAT_EXT   = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_GREY  = 2'd3
    } pat_e;

    typedef logic [23:0] rgb_t;

    localparam rgb_t RGB_BLACK     = 24'h000000;
    localparam rgb_t RGB_WHITE     = 24'hFFFFFF;
    localparam rgb_t RGB_GREY      = 24'h808080;
    localparam rgb_t RGB_UNDERFLOW = 24'hFF00FF;

    // Colour-bar palette, left to right.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFFFF00;
            3'd2:    return 24'h00FFFF;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'hFF00FF;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

endpackage

// File: rtl/video_timing_if.sv
// External pixel stream: source drives data/valid, the timing generator
// answers with ready during active pixels in external mode.
interface video_timing_if;
    import video_timing_pkg::*;

    rgb_t pix_data;
    logic pix_valid;
    logic pix_ready;

    modport master (output pix_data, output pix_valid, input pix_ready);
    modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/video_pattern.sv
// Combinational test-pattern source for the non-external pat_sel modes.
module video_pattern
    import video_timing_pkg::*;
(
    input  logic [15:0] h_cnt,
    input  logic [15:0] v_cnt,
    input  logic [2:0]  bar_idx,
    input  pat_e        sel,
    output rgb_t        pixel
);

    // Only bit 5 of each counter shapes the checkerboard.
    logic unused_cnt_bits;
    assign unused_cnt_bits = ^{h_cnt[15:6], h_cnt[4:0], v_cnt[15:6], v_cnt[4:0]};

    // Select the pattern pixel for the current counter position.
    // NOTE: assign a default first in always_comb so no path leaves pixel unassigned (no latch).
    always_comb begin
        pixel = RGB_BLACK;
        case (sel)
            PAT_BARS:  pixel = bar_colour(bar_idx);
            PAT_CHECK: pixel = (h_cnt[5] ^ v_cnt[5]) ? RGB_WHITE : RGB_BLACK;
            PAT_GREY:  pixel = RGB_GREY;
            default:   pixel = RGB_BLACK;
        endcase
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, registered sync/de/video, an
// external pixel stream with underflow fill, and built-in test patterns.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic [1:0]        pat_sel,
    video_timing_if.slave     pix,
    output logic              hs,
    output logic              vs,
    output logic              de,
    output rgb_t              video,
    output logic              frame_start,
    output logic [15:0]       underflow_cnt
);

    localparam logic [15:0] H_LAST   = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [15:0] V_LAST   = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
    localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [15:0] BAR_LAST = 16'(H_ACTIVE / 8 - 1);
    localparam logic        HS_ON    = (HS_POL != 0);
    localparam logic        VS_ON    = (VS_POL != 0);

    logic [15:0] h_cnt, v_cnt, bar_px;
    logic [2:0]  bar_idx;
    pat_e        pat_shadow, pat_eff;
    logic        origin, active, in_hs, in_vs, starved;
    rgb_t        pat_pixel, pixel_next;

    assign origin = (h_cnt == 16'd0) && (v_cnt == 16'd0);
    // At the frame origin the shadow is being loaded on this very edge, so
    // the live pat_sel already governs the first pixel of the new frame.
    assign pat_eff = origin ? pat_e'(pat_sel) : pat_shadow;
    assign active  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign in_hs   = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign in_vs   = (v_cnt >= VS_START) && (v_cnt < VS_END);

    assign pix.pix_ready = active && (pat_eff == PAT_EXT);
    assign starved       = pix.pix_ready && !pix.pix_valid;

    // Raster position: h wraps every line, v advances on each h wrap.
    // NOTE: every register here resets asynchronously so a mid-frame reset abandons the frame at once.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            // NOTE: non-blocking assignments keep all state updates tied to the same edge.
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 16'd0 : v_cnt + 16'd1;
        end else begin
            h_cnt <= h_cnt + 16'd1;
        end
    end

    // Bar index: restarts with each line and steps every H_ACTIVE/8 pixels.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (h_cnt == H_LAST) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (bar_px == BAR_LAST) begin
            bar_px  <= '0;
            bar_idx <= bar_idx + 3'd1;
        end else begin
            bar_px  <= bar_px + 16'd1;
        end
    end

    // Latch the pattern select once per frame, at the origin.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst)         pat_shadow <= PAT_EXT;
        else if (origin) pat_shadow <= pat_e'(pat_sel);
    end

    video_pattern u_pattern (
        .h_cnt   (h_cnt),
        .v_cnt   (v_cnt),
        .bar_idx (bar_idx),
        .sel     (pat_eff),
        .pixel   (pat_pixel)
    );

    // Choose the pixel for this position: blank, external, underflow fill or pattern.
    always_comb begin
        pixel_next = RGB_BLACK;
        if (active) begin
            if (pat_eff == PAT_EXT) pixel_next = pix.pix_valid ? pix.pix_data : RGB_UNDERFLOW;
            else                    pixel_next = pat_pixel;
        end
    end

    // Register the video outputs one pclk behind the counters.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hs          <= ~HS_ON;
            vs          <= ~VS_ON;
            de          <= 1'b0;
            video       <= RGB_BLACK;
            frame_start <= 1'b0;
        end else begin
            hs          <= in_hs ? HS_ON : ~HS_ON;
            vs          <= in_vs ? VS_ON : ~VS_ON;
            de          <= active;
            video       <= pixel_next;
            frame_start <= origin && active;
        end
    end

    // Count starved active pixels, saturating at all-ones.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst)                                       underflow_cnt <= '0;
        else if (starved && (underflow_cnt != 16'hFFFF)) underflow_cnt <= underflow_cnt + 16'd1;
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a reduced 80x40 raster
// (96 x 48 total) so several whole frames fit in a short run.
module tb_video_timing_gen;
    import video_timing_pkg::*;

    localparam int HA = 80, HF = 4, HSW = 8, HB = 4;
    localparam int VA = 40, VF = 2, VSW = 3, VB = 3;
    localparam int HT = 96, VT = 48;

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic [1:0]  pat_sel = 2'd1;
    logic        hs, vs, de, frame_start;
    rgb_t        video;
    logic [15:0] underflow_cnt;

    video_timing_if pix_if ();

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(0), .VS_POL(0)
    ) dut (
        .pclk          (pclk),
        .rst           (rst),
        .pat_sel       (pat_sel),
        .pix           (pix_if),
        .hs            (hs),
        .vs            (vs),
        .de            (de),
        .video         (video),
        .frame_start   (frame_start),
        .underflow_cnt (underflow_cnt)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    initial begin
        int fs_cnt, de_err, blank_err, ready_err, de_line0, hs_low, hs_first;
        int vs_lines, vs_first, starve_px;
        int px_err [5];
        logic [23:0] data_ctr, exp_px;
        logic        act;

        fs_cnt = 0; de_err = 0; blank_err = 0; ready_err = 0;
        de_line0 = 0; hs_low = 0; hs_first = -1; vs_lines = 0; vs_first = -1;
        starve_px = 0; data_ctr = 24'h000100;
        for (int i = 0; i < 5; i++) px_err[i] = 0;

        pix_if.pix_data  = 24'h0;
        pix_if.pix_valid = 1'b0;

        // Reset state.
        repeat (3) tick();
        check("rst_de", de, 0);
        check("rst_video", video, 24'h0);
        check("rst_hs", hs, 1);
        check("rst_vs", vs, 1);
        check("rst_fs", frame_start, 0);
        check("rst_unf", underflow_cnt, 0);
        rst = 1'b0;

        // Frame 1 bars (switch to grey mid-frame), frame 2 grey (switch to
        // checker), frame 3 checker (switch to external), frame 4 external
        // up to (30,20) where reset hits.
        for (int f = 1; f <= 4; f++) begin
            for (int v = 0; v < VT; v++) begin
                for (int h = 0; h < HT; h++) begin
                    if (!(f == 4 && (v > 20 || (v == 20 && h >= 30)))) begin
                        act = (h < HA) && (v < VA);
                        if (v == 20 && h == 0) begin
                            if (f == 1) pat_sel = 2'd3;
                            if (f == 2) pat_sel = 2'd2;
                            if (f == 3) pat_sel = 2'd0;
                        end
                        if (f == 4) begin
                            pix_if.pix_valid = !(v == 1 && h >= 10 && h < 13);
                            pix_if.pix_data  = data_ctr;
                        end
                        if (pix_if.pix_ready !== ((f == 4) && act)) ready_err++;
                        case (f)
                            1:       exp_px = bars[h / 10];
                            2:       exp_px = 24'h808080;
                            3:       exp_px = (((h >> 5) ^ (v >> 5)) & 1) ? 24'hFFFFFF : 24'h000000;
                            default: exp_px = pix_if.pix_valid ? data_ctr : 24'hFF00FF;
                        endcase
                        if (f == 4 && act && pix_if.pix_valid) data_ctr = data_ctr + 24'd1;

                        tick();

                        if (frame_start) fs_cnt++;
                        if (de !== act) de_err++;
                        if (!act && video !== 24'h0) blank_err++;
                        if (act && video !== exp_px) px_err[f]++;
                        if (f == 4 && act && video === 24'hFF00FF) starve_px++;
                        if (h == 0 && v == 0) check($sformatf("f%0d_origin_fs", f), frame_start, 1);
                        if (f == 1) begin
                            if (h == 0 && v == 0) begin
                                check("f1_first_de", de, 1);
                                check("f1_first_px", video, 24'hFFFFFF);
                            end
                            if (h == 75 && v == 0) check("f1_last_bar", video, 24'h000000);
                            if (h == 55 && v == 30) check("f1_bars_after_change", video, 24'hFF0000);
                            if (v == 0) begin
                                if (de) de_line0++;
                                if (hs === 1'b0) begin
                                    if (hs_first < 0) hs_first = h;
                                    hs_low++;
                                end
                            end
                            if (h == 0 && vs === 1'b0) begin
                                if (vs_first < 0) vs_first = v;
                                vs_lines++;
                            end
                        end
                        if (f == 3 && v == 5  && h == 5)  check("chk_5_5",  video, 24'h000000);
                        if (f == 3 && v == 5  && h == 40) check("chk_40_5", video, 24'hFFFFFF);
                        if (f == 3 && v == 35 && h == 40) check("chk_40_35", video, 24'h000000);
                        if (f == 3 && v == 35 && h == 5)  check("chk_5_35", video, 24'hFFFFFF);
                    end
                end
            end
        end

        check("line0_de_cycles", de_line0, 80);
        check("line0_hs_low_cycles", hs_low, 8);
        check("line0_hs_first_h", hs_first, 84);
        check("vs_low_lines", vs_lines, 3);
        check("vs_first_line", vs_first, 42);
        check("bars_pixels", px_err[1], 0);
        check("grey_pixels", px_err[2], 0);
        check("checker_pixels", px_err[3], 0);
        check("ext_pixels", px_err[4], 0);
        check("frame_start_count", fs_cnt, 4);
        check("de_vs_active", de_err, 0);
        check("blank_video_zero", blank_err, 0);
        check("ready_vs_active", ready_err, 0);
        check("starved_pixels", starve_px, 3);
        check("underflow_cnt", underflow_cnt, 3);

        // Reset mid-frame at h=30, v=20.
        rst = 1'b1;
        #1;
        check("midrst_de", de, 0);
        check("midrst_video", video, 24'h0);
        check("midrst_fs", frame_start, 0);
        check("midrst_unf", underflow_cnt, 0);
        tick();
        tick();
        rst = 1'b0;
        pix_if.pix_valid = 1'b1;
        pix_if.pix_data  = 24'hABCDEF;
        #1;
        check("post_rst_ready", pix_if.pix_ready, 1);
        tick();
        check("post_rst_fs", frame_start, 1);
        check("post_rst_de", de, 1);
        check("post_rst_video", video, 24'hABCDEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameters H_FP 16, H_SYNC 96, H_BP 48: horizontal front porch, sync and back porch widths in pixels.
REQ-003 Parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical active, front porch, sync and back porch heights in lines.
REQ-004 Parameters HS_POL 0 and VS_POL 0 set the sync active level (0 = active-low).
REQ-005 pclk  input  1  pixel clock; sole clock of the block.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 pat_sel  input  2  source select: 0 external pixels, 1 colour bars, 2 checkerboard, 3 solid grey.
REQ-008 pix_data  input  24  external pixel as {R[23:16], G[15:8], B[7:0]}.
REQ-009 pix_valid  input  1  pix_data holds a valid pixel.
REQ-010 pix_ready  output  1  block accepts pix_data this cycle.
REQ-011 hs, vs, de  output  1 each  registered sync and data-enable outputs for the TMDS stage.
REQ-012 video  output  24  registered pixel data, aligned with de.
REQ-013 frame_start  output  1  one-cycle pulse on the first active pixel of each frame.
REQ-014 underflow_cnt  output  16  saturating count of starved active pixels.

Function
REQ-015 Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
REQ-016 h_cnt counts 0..H_TOTAL-1 and wraps to 0; on each wrap, v_cnt increments, wrapping from V_TOTAL-1 to 0.
REQ-017 Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-018 hs is active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vs uses the same rule on v_cnt.
REQ-019 hs, vs, de and video are registered with exactly 1 pclk of latency from the counter state that produces them.
REQ-020 Outside the active region, video is 24'h000000.
REQ-021 frame_start is high in the same cycle as de for counter state (0,0), and is low otherwise.
REQ-022 pat_sel is captured into a shadow register only when h_cnt=0 and v_cnt=0; a mid-frame change takes effect from the next frame.
REQ-023 pix_ready is combinational: it is high iff the counters are in the active region and shadow pat_sel is 0.
REQ-024 A pixel is transferred when pix_ready and pix_valid are both high; the transferred pix_data appears on video in the next cycle, together with de.
REQ-025 If pix_ready is high and pix_valid is low, video is 24'hFF00FF for that pixel and underflow_cnt increments; underflow_cnt holds at 16'hFFFF.
REQ-026 Colour bars: 8 bars, each H_ACTIVE/8 pixels wide, in the order white, yellow, cyan, green, magenta, red, blue, black (FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000).
REQ-027 The bar index is held in a counter that resets at h_cnt=0 and advances every H_ACTIVE/8 pixels; no divider is used.
REQ-028 Checkerboard: the pixel is FFFFFF when h_cnt[5]^v_cnt[5] is 1, else 000000.
REQ-029 Solid grey: the pixel is 808080.
REQ-030 pix_valid is ignored whenever pix_ready is low.

Reset
REQ-031 While rst is high: h_cnt=0, v_cnt=0, shadow pat_sel=0, de=0, video=0, frame_start=0, underflow_cnt=0, hs=~HS_POL and vs=~VS_POL.
REQ-032 Reset asserted mid-frame abandons the frame immediately.
REQ-033 The first rising pclk edge after rst deasserts processes counter state (0,0), so a new frame starts at once.

Structure
REQ-034 A shared package video_timing_pkg holds the default 640x480 timing constants, the pat_sel encodings and the colour-bar/underflow colour constants.
REQ-035 Pattern generation is a separate sub-module, video_pattern: inputs are the counters, the bar index and the shadow pat_sel; output is a 24-bit combinational pixel.

Verification
REQ-036 Release rst, pat_sel=1 -> frame_start at output cycle 1; de high for 640 cycles per line; first 80 pixels FFFFFF, pixels 560-639 000000.
REQ-037 Count cycles over one line and one frame -> hs low for 96 cycles starting at h=656; vs low for 2 lines starting at v=490; 800x525 = 420000 cycles per frame.
REQ-038 pat_sel=0, pix_valid tied high, pix_data = incrementing count -> video equals the transferred value 1 cycle later; pix_ready low during blanking.
REQ-039 pat_sel=0, pix_valid deasserted for 3 active cycles -> video = FF00FF on those 3 pixels; underflow_cnt increases by 3.
REQ-040 Change pat_sel from 1 to 3 at v=100 -> bars continue to the end of the frame; the next frame is all 808080.
REQ-041 Assert rst at h=300, v=200 -> de=0 and video=0 immediately; after release, frame_start appears again on the first cycle.
